// File: rtl/mips_pkg.sv
// Shared constants for the MIPS core: default datapath widths and architectural register indices.
package mips_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int REG_ZERO  = 0;
    localparam int REG_SP    = 29;
    localparam logic [31:0] SP_RESET = 32'h0000_0200;

endpackage

// File: rtl/rf_read_mux.sv
// One register-file read port: write-before-read bypass with youngest-writer priority,
// hardwired zero register, and busy masking when the operand is being forwarded.
module rf_read_mux
    import mips_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NUM_WR = 2
) (
    input  logic [ADDR_W-1:0]        rd_addr,
    input  logic [DATA_W-1:0]        reg_data,
    input  logic                     reg_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_busy
);

    logic hit;

    // NOTE: every output of this block gets a default first so no path can infer a latch.
    always_comb begin
        rd_data = reg_data;
        hit     = 1'b0;
        // Ascending scan: a later (younger) matching port overrides an earlier one.
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] == rd_addr)) begin
                hit     = 1'b1;
                rd_data = wr_data[p*DATA_W +: DATA_W];
            end
        end
        rd_busy = reg_busy && !hit;
        if (rd_addr == ADDR_W'(REG_ZERO)) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/multiport_register_file.sv
// General-purpose register file for the ID stage: NUM_RD bypassed read ports, NUM_WR write ports
// and a one-bit-per-register busy scoreboard (set at issue, cleared at writeback).
module multiport_register_file
    import mips_pkg::*;
#(
    parameter int                 DATA_W  = RF_DATA_W,
    parameter int                 ADDR_W  = RF_ADDR_W,
    parameter int                 NUM_RD  = 2,
    parameter int                 NUM_WR  = 2,
    parameter int                 SP_IDX  = REG_SP,
    parameter logic [DATA_W-1:0]  SP_INIT = DATA_W'(SP_RESET)
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*ADDR_W-1:0] wr_addr,
    input  logic [NUM_WR*DATA_W-1:0] wr_data,
    input  logic                     iss_valid,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic [2**ADDR_W-1:0]     busy_vec
);

    localparam int DEPTH = 2**ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_nxt;

    // NOTE: the storage array is reset explicitly; an async reset keeps it in flops, not a RAM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= (i == SP_IDX) ? SP_INIT : '0;
            end
        end else begin
            // NOTE: non-blocking writes in port order, so the highest-index port lands last and wins.
            for (int p = 0; p < NUM_WR; p++) begin
                if (wr_en[p] && (wr_addr[p*ADDR_W +: ADDR_W] != ADDR_W'(REG_ZERO))) begin
                    regs[wr_addr[p*ADDR_W +: ADDR_W]] <= wr_data[p*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Writeback clears first, then issue sets: a younger producer keeps the register busy.
    always_comb begin
        busy_nxt = busy_q;
        for (int p = 0; p < NUM_WR; p++) begin
            if (wr_en[p]) begin
                busy_nxt[wr_addr[p*ADDR_W +: ADDR_W]] = 1'b0;
            end
        end
        if (iss_valid) begin
            busy_nxt[iss_addr] = 1'b1;
        end
        busy_nxt[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_nxt;
        end
    end

    assign busy_vec = busy_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr_k;
        assign addr_k = rd_addr[k*ADDR_W +: ADDR_W];

        rf_read_mux #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .NUM_WR (NUM_WR)
        ) u_rd_mux (
            .rd_addr  (addr_k),
            .reg_data (regs[addr_k]),
            .reg_busy (busy_q[addr_k]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule

// File: tb/tb_multiport_register_file.sv
// Self-checking bench for multiport_register_file: a register/scoreboard model checked every
// cycle on the falling edge, plus directed literal expectations for the key scenarios.
module tb_multiport_register_file;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;
    localparam int NW = 2;

    logic              clk;
    logic              reset_n;
    logic [NR*AW-1:0]  rd_addr;
    logic [NR*DW-1:0]  rd_data;
    logic [NR-1:0]     rd_busy;
    logic [NW-1:0]     wr_en;
    logic [NW*AW-1:0]  wr_addr;
    logic [NW*DW-1:0]  wr_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_addr;
    logic [2**AW-1:0]  busy_vec;

    int checks = 0;
    int errors = 0;
    bit compare_en = 1'b0;

    logic [DW-1:0]    mdl_regs [2**AW];
    logic [2**AW-1:0] mdl_busy;

    multiport_register_file #(
        .DATA_W (DW),
        .ADDR_W (AW),
        .NUM_RD (NR),
        .NUM_WR (NW)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_busy   (rd_busy),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .iss_valid (iss_valid),
        .iss_addr  (iss_addr),
        .busy_vec  (busy_vec)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Architectural state model: register contents and busy bits as the rules define them.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int r = 0; r < 2**AW; r++) mdl_regs[r] = (r == 29) ? 32'h200 : 32'h0;
            mdl_busy = '0;
        end else begin
            for (int p = 0; p < NW; p++) begin
                if (wr_en[p] && wr_addr[p*AW +: AW] != 0) mdl_regs[wr_addr[p*AW +: AW]] = wr_data[p*DW +: DW];
                if (wr_en[p]) mdl_busy[wr_addr[p*AW +: AW]] = 1'b0;
            end
            if (iss_valid && iss_addr != 0) mdl_busy[iss_addr] = 1'b1;
        end
    end

    // Youngest matching writer first, then stored value.
    function automatic logic [DW-1:0] exp_rd(input int k);
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (a == 0) return '0;
        for (int p = NW-1; p >= 0; p--)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) return wr_data[p*DW +: DW];
        return mdl_regs[a];
    endfunction

    function automatic logic exp_busy(input int k);
        logic [AW-1:0] a;
        a = rd_addr[k*AW +: AW];
        if (a == 0) return 1'b0;
        for (int p = 0; p < NW; p++)
            if (wr_en[p] && wr_addr[p*AW +: AW] == a) return 1'b0;
        return mdl_busy[a];
    endfunction

    always @(negedge clk) begin
        if (compare_en) begin
            for (int k = 0; k < NR; k++) begin
                check($sformatf("rd_data%0d", k), 64'(rd_data[k*DW +: DW]), 64'(exp_rd(k)));
                check($sformatf("rd_busy%0d", k), 64'(rd_busy[k]), 64'(exp_busy(k)));
            end
            check("busy_vec", 64'(busy_vec), 64'(mdl_busy));
        end
    end

    task automatic set_rd(input int k, input logic [AW-1:0] a);
        rd_addr[k*AW +: AW] = a;
    endtask

    task automatic set_wr(input int p, input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en[p]            = en;
        wr_addr[p*AW +: AW] = a;
        wr_data[p*DW +: DW] = d;
    endtask

    task automatic idle();
        wr_en     = '0;
        iss_valid = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rd_addr   = '0;
        wr_en     = '0;
        wr_addr   = '0;
        wr_data   = '0;
        iss_valid = 1'b0;
        iss_addr  = '0;
        reset_n   = 1'b1;
        #1 reset_n = 1'b0;
        set_rd(0, 5'd29);
        set_rd(1, 5'd5);
        #2;
        check("reset_sp", 64'(rd_data[0 +: DW]), 64'h200);
        check("reset_r5", 64'(rd_data[DW +: DW]), 64'h0);
        check("reset_busy_vec", 64'(busy_vec), 64'h0);
        compare_en = 1'b1;
        @(posedge clk);
        cyc();
        reset_n = 1'b1;

        // Write then read back; writes to reg 0 are dropped.
        set_wr(0, 1'b1, 5'd8, 32'hDEAD_BEEF);
        cyc();
        idle();
        set_rd(0, 5'd8);
        #2 check("rd_reg8", 64'(rd_data[0 +: DW]), 64'hDEAD_BEEF);
        set_wr(0, 1'b1, 5'd0, 32'h1234);
        set_rd(1, 5'd0);
        #2 check("rd_reg0_bypass", 64'(rd_data[DW +: DW]), 64'h0);
        cyc();
        idle();
        #2 check("rd_reg0_stored", 64'(rd_data[DW +: DW]), 64'h0);

        // Same-cycle conflict: port 1 wins for both bypass and storage.
        set_wr(0, 1'b1, 5'd3, 32'h11);
        set_wr(1, 1'b1, 5'd3, 32'h22);
        set_rd(0, 5'd3);
        #2 check("bypass_conflict", 64'(rd_data[0 +: DW]), 64'h22);
        cyc();
        idle();
        set_wr(0, 1'b0, 5'd3, 32'h99);
        #2 check("no_bypass_without_en", 64'(rd_data[0 +: DW]), 64'h22);
        cyc();

        // Scoreboard set, then cleared by writeback with bypass masking busy.
        iss_valid = 1'b1;
        iss_addr  = 5'd7;
        set_rd(0, 5'd7);
        #2 check("busy7_before_edge", 64'(rd_busy[0]), 64'h0);
        cyc();
        iss_valid = 1'b0;
        #2;
        check("busy7_rd", 64'(rd_busy[0]), 64'h1);
        check("busy7_vec", 64'(busy_vec[7]), 64'h1);
        set_wr(0, 1'b1, 5'd7, 32'h77);
        #2;
        check("busy7_bypassed", 64'(rd_busy[0]), 64'h0);
        check("rd7_bypassed", 64'(rd_data[0 +: DW]), 64'h77);
        cyc();
        idle();
        #2 check("busy7_cleared", 64'(busy_vec[7]), 64'h0);

        // Set/clear collision keeps the bit; reg 0 issue never marks busy.
        iss_valid = 1'b1;
        iss_addr  = 5'd9;
        cyc();
        set_wr(1, 1'b1, 5'd9, 32'h5);
        cyc();
        idle();
        set_rd(1, 5'd9);
        #2;
        check("collision_busy9", 64'(busy_vec[9]), 64'h1);
        check("collision_reg9", 64'(rd_data[DW +: DW]), 64'h5);
        check("collision_rd_busy9", 64'(rd_busy[1]), 64'h1);
        iss_valid = 1'b1;
        iss_addr  = 5'd0;
        cyc();
        idle();
        #2 check("busy0_never", 64'(busy_vec[0]), 64'h0);

        // Mixed traffic on both ports.
        for (int i = 0; i < 12; i++) begin
            set_wr(0, 1'(i % 2), 5'(i + 10), 32'h1000 + 32'(i));
            set_wr(1, 1'(i % 3 == 0), 5'(i + 11), 32'h2000 + 32'(i));
            iss_valid = 1'(i % 4 != 3);
            iss_addr  = 5'(i + 12);
            set_rd(0, 5'(i + 10));
            set_rd(1, 5'(i + 11));
            cyc();
        end
        idle();
        cyc();

        // Async reset between edges clears state immediately.
        set_wr(0, 1'b1, 5'd4, 32'h44);
        cyc();
        idle();
        iss_valid = 1'b1;
        iss_addr  = 5'd4;
        cyc();
        iss_addr  = 5'd6;
        cyc();
        idle();
        set_rd(0, 5'd4);
        #2;
        check("pre_reset_busy46", 64'({busy_vec[6], busy_vec[4]}), 64'h3);
        check("pre_reset_reg4", 64'(rd_data[0 +: DW]), 64'h44);
        reset_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy_vec), 64'h0);
        check("async_reset_reg4", 64'(rd_data[0 +: DW]), 64'h0);
        #2 reset_n = 1'b1;
        set_wr(0, 1'b1, 5'd10, 32'hAB);
        cyc();
        idle();
        set_rd(0, 5'd10);
        #2 check("first_write_after_reset", 64'(rd_data[0 +: DW]), 64'hAB);
        cyc();
        cyc();

        compare_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
